// File: rtl/lfsr_gen.sv
// Fibonacci LFSR: STEPS shifts per enabled cycle, runtime seed load, wrap pulse and lock-up flag.
// Latency 1 cycle from i_enable/i_load to o_value; no backpressure. Optional LFSR_GEN_LOCKUP_RECOVER_EN.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_value,
    output logic             o_wrap,
    output logic             o_lockup
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH out of range");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS out of range");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] stepped;
    logic             lockup;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    always_comb begin
        stepped = state_q;
        for (int i = 0; i < STEPS; i++) begin
            stepped = shift1(stepped);
        end
    end

    assign lockup = (state_q == '0);

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        wrap_d  = 1'b0;
        if (i_load) begin
            state_d = i_seed;
            start_d = i_seed;
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
        end else if (lockup && i_enable) begin
            // Escape the zero state by restarting the sequence from the reset seed.
            state_d = SEED;
            start_d = SEED;
`endif
        end else if (i_enable) begin
            state_d = stepped;
            wrap_d  = (stepped == start_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
            start_q <= SEED;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_value  = state_q;
    assign o_wrap   = wrap_q;
    assign o_lockup = lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: STEPS=1 instance for sequence/period/lock-up/reset, STEPS=2 instance for multi-step and load.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, ld;
    logic [7:0] seed, val;
    logic       wrap, lock;

    logic       en2, ld2;
    logic [7:0] seed2, val2;
    logic       wrap2, lock2;

    int checks = 0;
    int errors = 0;

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) u_dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_load(ld), .i_seed(seed),
        .o_value(val), .o_wrap(wrap), .o_lockup(lock)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_enable(en2), .i_load(ld2), .i_seed(seed2),
        .o_value(val2), .o_wrap(wrap2), .o_lockup(lock2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs 255 enabled cycles; reports the first cycle with o_wrap and the count of distinct non-zero values.
    task automatic run_period(output int first_wrap, output int distinct, output logic [7:0] last);
        bit seen [256];
        foreach (seen[i]) seen[i] = 1'b0;
        first_wrap = 0;
        distinct   = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (wrap && first_wrap == 0) first_wrap = k;
            if (val != 8'h00 && !seen[val]) begin
                seen[val] = 1'b1;
                distinct++;
            end
        end
        last = val;
    endtask

    logic [7:0] seq_exp [6];
    int         fw, nd;
    logic [7:0] last_v;

    initial begin
        seq_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
        rst = 1'b1; en = 1'b0; ld = 1'b0; seed = 8'h00;
        en2 = 1'b0; ld2 = 1'b0; seed2 = 8'h00;

        repeat (3) tick();
        chk("reset_value", val, 8'h01);
        chk("reset_lockup", lock, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        chk("reset_value_s2", val2, 8'h01);

        // Sequence on STEPS=1 while the STEPS=2 instance runs its step/load vectors alongside.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1: begin en2 = 1'b1; ld2 = 1'b0; end
                2:    begin en2 = 1'b1; ld2 = 1'b1; seed2 = 8'h23; end
                3:    begin en2 = 1'b1; ld2 = 1'b0; end
                default: begin en2 = 1'b0; ld2 = 1'b0; end
            endcase
            tick();
            chk($sformatf("seq_%0d", i), val, seq_exp[i]);
            chk($sformatf("seq_wrap_%0d", i), wrap, 1'b0);
            case (i)
                0: chk("s2_step1", val2, 8'h04);
                1: chk("s2_step2", val2, 8'h11);
                2: begin chk("s2_load_no_step", val2, 8'h23); chk("s2_load_wrap", wrap2, 1'b0); end
                3: chk("s2_after_load", val2, 8'h8E);
                default: ;
            endcase
        end

        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gate_frozen", val, 8'h47);
            chk("gate_wrap", wrap, 1'b0);
        end
        en = 1'b1;
        tick();
        chk("gate_resume", val, 8'h8E);

        // Full period from reset.
        en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        run_period(fw, nd, last_v);
        chk("period_first_wrap", fw, 255);
        chk("period_end_value", last_v, 8'h01);
        chk("period_distinct", nd, 255);
        tick();
        chk("repeat_value", val, 8'h02);
        chk("repeat_wrap", wrap, 1'b0);

        // Back-to-back loads: last one wins.
        en = 1'b0; ld = 1'b1; seed = 8'h10;
        tick();
        seed = 8'h5A;
        tick();
        chk("b2b_load_value", val, 8'h5A);
        chk("b2b_load_wrap", wrap, 1'b0);
        ld = 1'b0; en = 1'b1;
        tick();
        chk("b2b_step", val, 8'hB4);

        // Lock-up.
        en = 1'b0; ld = 1'b1; seed = 8'h00;
        tick();
        ld = 1'b0;
        chk("lock_value", val, 8'h00);
        chk("lock_flag", lock, 1'b1);
        en = 1'b1;
        tick();
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
        chk("lock_recover_value", val, 8'h01);
        chk("lock_recover_flag", lock, 1'b0);
        chk("lock_recover_wrap", wrap, 1'b0);
        tick();
        chk("lock_after_recover", val, 8'h02);
        chk("lock_after_wrap", wrap, 1'b0);
`else
        chk("lock_stuck_value", val, 8'h00);
        chk("lock_stuck_flag", lock, 1'b1);
        chk("lock_zero_wrap", wrap, 1'b1);
        tick();
        chk("lock_stuck_value2", val, 8'h00);
        chk("lock_zero_wrap2", wrap, 1'b1);
`endif

        // Reset mid-run after a load of 5A; wrap tracking returns to SEED.
        en = 1'b0; ld = 1'b1; seed = 8'h5A;
        tick();
        ld = 1'b0; en = 1'b1;
        repeat (3) tick();
        rst = 1'b1; ld = 1'b1; seed = 8'h77;
        tick();
        chk("midrst_value", val, 8'h01);
        chk("midrst_wrap", wrap, 1'b0);
        chk("midrst_lockup", lock, 1'b0);
        rst = 1'b0; ld = 1'b0; en = 1'b1;
        run_period(fw, nd, last_v);
        chk("midrst_first_wrap", fw, 255);
        chk("midrst_wrap_value", last_v, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised successor to the 8-bit LFSR pseudo-random source. It is a Fibonacci LFSR with configurable width, tap mask and reset seed, and advances STEPS bits per enabled clock. It adds a runtime seed load, lock-up (all-zero state) detection and a sequence-wrap pulse. It sits in test-pattern and scrambler paths wherever a gated pseudo-random word is needed.

## Interface
- WIDTH, 8: state and output width, 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits; bit i set means state[i] feeds the XOR.
- SEED, 8'h01: reset and recovery state, WIDTH bits, must be non-zero.
- STEPS, 1: LFSR shifts per enabled cycle, 1..WIDTH.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  advance the state by STEPS shifts this cycle.
- i_load  in  1  load i_seed into the state this cycle.
- i_seed  in  WIDTH  value to load.
- o_value  out  WIDTH  current state.
- o_wrap  out  1  one-cycle pulse: the sequence returned to its start value.
- o_lockup  out  1  state is all-zero.

## Operation
- Single shift: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
- An enabled cycle applies the single shift STEPS times combinationally (unrolled), then registers the result.
- Start register: holds the value the sequence began from.
  - Set to SEED on reset.
  - Set to i_seed on load.
- Priority per cycle, highest first: rst, i_load, lock-up recovery (macro only), i_enable, hold.
- Load:
  - state <= i_seed and start <= i_seed.
  - o_wrap is 0 in the next cycle.
  - i_enable is ignored in the same cycle.
- Enabled step: state <= stepped value. If the stepped value == start, o_wrap = 1 in the next cycle, otherwise 0.
- Hold (i_enable = 0, no load): state unchanged and o_wrap = 0.
- Wrap is detected only when an enabled step lands exactly on start. For STEPS > 1 it fires only if the period is a multiple of STEPS, or after lcm(period, STEPS)/STEPS cycles.
- o_lockup = (state == 0). It is decoded from the state register and adds no register stage. The zero state is reachable only via i_load with i_seed = 0.
- In the zero state a plain step leaves the state 0. A zero-to-zero step counts as a wrap when start is 0 and pulses o_wrap each enabled cycle.

## Timing
- Reset values: o_value = SEED, o_wrap = 0, o_lockup = 0, start = SEED.
- rst asserted mid-operation: all state returns to the reset values on the next edge and overrides i_load and i_enable.
- Latency from i_enable or i_load to o_value: 1 cycle.
- o_wrap is registered and is high in the same cycle o_value shows the start value.
- No handshake: i_enable is level-sensitive, one advance per high cycle. i_enable may stay high indefinitely.
- Back-to-back loads: the last one wins, and each load resets wrap tracking.

## Configuration
- LFSR_GEN_LOCKUP_RECOVER_EN:
  - Defined: when state == 0 and i_enable = 1 with no load, the state is forced to SEED and start to SEED. o_wrap = 0 that cycle. o_lockup is high for exactly the one cycle the zero state was visible.
  - Undefined: no recovery. The zero state persists until load or reset, and o_lockup stays high.

## Test plan
- Reset and sequence (WIDTH=8, TAPS=8'hB8, SEED=8'h01, STEPS=1):
  - Hold rst 3 cycles: o_value = 8'h01 and o_lockup = 0.
  - Then i_enable = 1: o_value goes 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47 on consecutive cycles.
- Enable gating: drop i_enable for 10 cycles mid-sequence -> o_value frozen and o_wrap = 0. Re-enable -> the sequence resumes from the frozen value.
- Full period: enable continuously from reset -> 255 distinct non-zero values. o_value = 8'h01 with o_wrap = 1 exactly on the 255th enabled cycle, then the sequence repeats.
- Load and STEPS: with STEPS=2 from reset, one enabled cycle gives 8'h04 and the next 8'h11. Load i_seed = 8'h23 with i_enable = 1 in the same cycle -> o_value = 8'h23 (no step). The next enabled cycle gives 8'h8E.
- Lock-up: load 8'h00 -> o_lockup = 1 next cycle. Then enable:
  - With the macro: o_value = 8'h01 one cycle later and o_lockup = 0.
  - Without the macro: o_value stays 8'h00 and o_lockup stays 1 until reset.
- Reset mid-run: assert rst during enabled stepping after a load of 8'h5A -> next cycle o_value = 8'h01 and o_wrap = 0. Wrap now fires on returning to 8'h01, not 8'h5A.
